// File: rtl/writeback_pkg.sv
// -----------------------------------------------------------------------------
// writeback_pkg
//   Shared types and helpers for the writeback stage with its store buffer.
//   - wb_op_t    : retiring-instruction class seen by writeback
//   - wb_state_t : syscall sequencer states
//   - sb_entry_t : one buffered store {addr, size-masked data, size}
//   - size_mask_data : zero-extends store data from its access size
// -----------------------------------------------------------------------------
package writeback_pkg;

  localparam int PKG_ADDR_W = 64;
  localparam int PKG_XLEN   = 64;

  // Store access sizes, log2 of the byte count.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [2:0] {
    OP_ALU   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_ECALL = 3'd3,
    OP_HALT  = 3'd4,
    OP_NOP   = 3'd5
  } wb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CALL  = 2'd2,
    ST_WRITE = 2'd3
  } wb_state_t;

  // The entry layout is sized by the package widths; the top-level ADDR_W and
  // XLEN parameters are expected to keep their default values.
  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_XLEN-1:0]   data;
    logic [1:0]            size;
  } sb_entry_t;

  // Keep only the bytes covered by the access size; upper bytes read as zero.
  function automatic logic [PKG_XLEN-1:0] size_mask_data(
    input logic [PKG_XLEN-1:0] data,
    input logic [1:0]          size
  );
    logic [PKG_XLEN-1:0] res;
    res = '0;
    case (size)
      SIZE_B:  res[7:0]  = data[7:0];
      SIZE_H:  res[15:0] = data[15:0];
      SIZE_W:  res[31:0] = data[31:0];
      SIZE_D:  res       = data;
      default: res       = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sbuf_fifo.sv
// -----------------------------------------------------------------------------
// sbuf_fifo
//   Generic synchronous FIFO used as the in-order store buffer.
//   A push while full is honoured only when a pop happens in the same cycle,
//   so a full buffer can stream one-in/one-out without losing an entry.
// Ports
//   clk, reset     clock, synchronous active-high reset (empties the FIFO)
//   push, wdata    enqueue request and data
//   pop            dequeue request (ignored when empty)
//   rdata          head entry (only meaningful when !empty)
//   full, empty    occupancy flags
//   count          number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sbuf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occupancy;
  logic             do_push;
  logic             do_pop;

  assign full    = (occupancy == CNT_W'(DEPTH));
  assign empty   = (occupancy == {CNT_W{1'b0}});
  assign count   = occupancy;
  assign rdata   = storage[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Entry storage: written at the tail, no reset needed (guarded by empty).
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy counter; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= {CNT_W{1'b0}};
    end else begin
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/writeback_sbuf.sv
// -----------------------------------------------------------------------------
// writeback_sbuf
//   Writeback stage: retires one instruction per cycle, writes rd to the
//   regfile with one cycle of latency, buffers stores in an in-order store
//   buffer that drains over a valid/ready memory port, and sequences syscalls
//   (drain buffer -> call environment -> write a0) with a pipeline flush.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          retire handshake
//   in_op, in_size             operation class and store size (log2 bytes)
//   in_alu_result, in_mdata    result sources for rd (ALU/LOAD)
//   in_store_data, in_addr     store payload and address
//   in_rd_regno, in_update_rd  destination register and its write enable
//   wb_valid/regno/data        registered regfile write port
//   mem_valid/ready/addr/data/size  store-buffer drain port
//   ecall_req/ack/ret          syscall handshake with the environment
//   syscall_flush              one-cycle flush on ECALL accept
//   halt                       sticky end-of-program flag
//   sb_count                   store-buffer occupancy
// -----------------------------------------------------------------------------
module writeback_sbuf
  import writeback_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int XLEN     = 64,
  parameter int REGNO_W  = 5,
  parameter int SB_DEPTH = 4,
  parameter int A0_REGNO = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [1:0]                in_size,
  input  logic [XLEN-1:0]           in_alu_result,
  input  logic [XLEN-1:0]           in_mdata,
  input  logic [XLEN-1:0]           in_store_data,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [REGNO_W-1:0]        in_rd_regno,
  input  logic                      in_update_rd,
  output logic                      wb_valid,
  output logic [REGNO_W-1:0]        wb_regno,
  output logic [XLEN-1:0]           wb_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [XLEN-1:0]           mem_data,
  output logic [1:0]                mem_size,
  output logic                      ecall_req,
  input  logic                      ecall_ack,
  input  logic [XLEN-1:0]           ecall_ret,
  output logic                      syscall_flush,
  output logic                      halt,
  output logic [$clog2(SB_DEPTH):0] sb_count
);

  localparam int ENTRY_W = $bits(sb_entry_t);

  wb_op_t            op;
  wb_state_t         state;
  wb_state_t         state_next;
  sb_entry_t         sb_wentry;
  sb_entry_t         sb_head;
  logic              sb_full;
  logic              sb_empty;
  logic              sb_push;
  logic              sb_pop;
  logic              fire;
  logic              wb_valid_next;
  logic [REGNO_W-1:0] wb_regno_next;
  logic [XLEN-1:0]   wb_data_next;

  assign op = wb_op_t'(in_op);

  // Accept rules. A store into a full buffer is allowed when the head is
  // leaving in the same cycle; HALT waits for every buffered store to drain.
  always_comb begin
    in_ready = 1'b1;
    if (reset || halt || (state != ST_IDLE)) begin
      in_ready = 1'b0;
    end else if ((op == OP_STORE) && sb_full && !mem_ready) begin
      in_ready = 1'b0;
    end else if ((op == OP_HALT) && !sb_empty) begin
      in_ready = 1'b0;
    end else begin
      in_ready = 1'b1;
    end
  end

  assign fire          = in_valid && in_ready;
  assign sb_push       = fire && (op == OP_STORE);
  assign syscall_flush = fire && (op == OP_ECALL);
  assign mem_valid     = !reset && !sb_empty;
  assign sb_pop        = mem_valid && mem_ready;
  assign ecall_req     = !reset && (state == ST_CALL);

  assign sb_wentry.addr = in_addr;
  assign sb_wentry.data = size_mask_data(in_store_data, in_size);
  assign sb_wentry.size = in_size;

  // Drain port shows zeros whenever there is nothing to present.
  assign mem_addr = mem_valid ? sb_head.addr : {ADDR_W{1'b0}};
  assign mem_data = mem_valid ? sb_head.data : {XLEN{1'b0}};
  assign mem_size = mem_valid ? sb_head.size : 2'd0;

  sbuf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (SB_DEPTH)
  ) u_sbuf (
    .clk   (clk),
    .reset (reset),
    .push  (sb_push),
    .wdata (sb_wentry),
    .pop   (sb_pop),
    .rdata (sb_head),
    .full  (sb_full),
    .empty (sb_empty),
    .count (sb_count)
  );

  // Syscall sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Syscall sequencer next state: DRAIN checks emptiness in its own cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (fire && (op == OP_ECALL)) begin
          state_next = ST_DRAIN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (sb_empty) begin
          state_next = ST_CALL;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      ST_CALL: begin
        if (ecall_ack) begin
          state_next = ST_WRITE;
        end else begin
          state_next = ST_CALL;
        end
      end
      ST_WRITE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Regfile write selection. The syscall return value is captured straight
  // into the write register on ack, so it appears while the FSM is in WRITE.
  always_comb begin
    wb_valid_next = 1'b0;
    wb_regno_next = {REGNO_W{1'b0}};
    wb_data_next  = {XLEN{1'b0}};
    if ((state == ST_CALL) && ecall_ack) begin
      wb_valid_next = 1'b1;
      wb_regno_next = REGNO_W'(A0_REGNO);
      wb_data_next  = ecall_ret;
    end else if (fire && ((op == OP_ALU) || (op == OP_LOAD)) && in_update_rd &&
                 (in_rd_regno != {REGNO_W{1'b0}})) begin
      wb_valid_next = 1'b1;
      wb_regno_next = in_rd_regno;
      wb_data_next  = (op == OP_LOAD) ? in_mdata : in_alu_result;
    end else begin
      wb_valid_next = 1'b0;
    end
  end

  // Registered regfile write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_regno <= {REGNO_W{1'b0}};
      wb_data  <= {XLEN{1'b0}};
    end else begin
      wb_valid <= wb_valid_next;
      wb_regno <= wb_regno_next;
      wb_data  <= wb_data_next;
    end
  end

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt <= 1'b0;
    end else if (fire && (op == OP_HALT)) begin
      halt <= 1'b1;
    end else begin
      halt <= halt;
    end
  end

endmodule

// File: tb/tb_writeback_sbuf.sv
module tb_writeback_sbuf;

  localparam int DEPTH = 4;
  localparam logic [2:0] OP_ALU   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_HALT  = 3'd4;
  localparam logic [2:0] OP_NOP   = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [1:0]  in_size = 2'd0;
  logic [63:0] in_alu_result = 64'd0;
  logic [63:0] in_mdata = 64'd0;
  logic [63:0] in_store_data = 64'd0;
  logic [63:0] in_addr = 64'd0;
  logic [4:0]  in_rd_regno = 5'd0;
  logic        in_update_rd = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_regno;
  logic [63:0] wb_data;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_addr;
  logic [63:0] mem_data;
  logic [1:0]  mem_size;
  logic        ecall_req;
  logic        ecall_ack = 1'b0;
  logic [63:0] ecall_ret = 64'd0;
  logic        syscall_flush;
  logic        halt;
  logic [2:0]  sb_count;

  int n_checks = 0;
  int n_fail = 0;

  writeback_sbuf dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_size(in_size), .in_alu_result(in_alu_result),
    .in_mdata(in_mdata), .in_store_data(in_store_data), .in_addr(in_addr),
    .in_rd_regno(in_rd_regno), .in_update_rd(in_update_rd),
    .wb_valid(wb_valid), .wb_regno(wb_regno), .wb_data(wb_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_size(mem_size), .ecall_req(ecall_req),
    .ecall_ack(ecall_ack), .ecall_ret(ecall_ret), .syscall_flush(syscall_flush),
    .halt(halt), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } ent_t;

  ent_t        q[$];
  int          phase;        // 0 running, 1 draining, 2 waiting on env, 3 writing a0
  bit          m_halt;
  bit          m_wb_valid;
  logic [4:0]  m_wb_regno;
  logic [63:0] m_wb_data;

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    if (sz == 2'd3) return {64{1'b1}};
    return (64'd1 << (8 * (1 << sz))) - 64'd1;
  endfunction

  function automatic bit exp_ready();
    if (reset || m_halt || phase != 0) return 1'b0;
    if (in_op == OP_STORE && q.size() == DEPTH && !mem_ready) return 1'b0;
    if (in_op == OP_HALT && q.size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    phase = 0;
    m_halt = 1'b0;
    m_wb_valid = 1'b0;
    m_wb_regno = 5'd0;
    m_wb_data = 64'd0;
  endtask

  task automatic model_step();
    bit acc;
    int n;
    ent_t e;
    if (reset) begin
      model_reset();
      return;
    end
    acc = in_valid && exp_ready();
    n = q.size();
    m_wb_valid = 1'b0;
    if (phase == 2 && ecall_ack) begin
      m_wb_valid = 1'b1;
      m_wb_regno = 5'd10;
      m_wb_data = ecall_ret;
    end else if (acc && (in_op == OP_ALU || in_op == OP_LOAD) && in_update_rd && in_rd_regno != 5'd0) begin
      m_wb_valid = 1'b1;
      m_wb_regno = in_rd_regno;
      m_wb_data = (in_op == OP_LOAD) ? in_mdata : in_alu_result;
    end
    case (phase)
      0: if (acc && in_op == OP_ECALL) phase = 1;
      1: if (n == 0) phase = 2;
      2: if (ecall_ack) phase = 3;
      default: phase = 0;
    endcase
    if (n > 0 && mem_ready) void'(q.pop_front());
    if (acc && in_op == OP_STORE) begin
      e.addr = in_addr;
      e.data = in_store_data & size_mask(in_size);
      e.size = in_size;
      q.push_back(e);
    end
    if (acc && in_op == OP_HALT) m_halt = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_outputs();
    bit er;
    bit mv;
    er = exp_ready();
    mv = !reset && q.size() > 0;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("syscall_flush", 64'(syscall_flush), 64'(in_valid && er && in_op == OP_ECALL));
    chk("mem_valid", 64'(mem_valid), 64'(mv));
    if (mv) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_data", mem_data, q[0].data);
      chk("mem_size", 64'(mem_size), 64'(q[0].size));
    end
    chk("ecall_req", 64'(ecall_req), 64'(!reset && phase == 2));
    chk("sb_count", 64'(sb_count), 64'(q.size()));
    chk("halt", 64'(halt), 64'(m_halt));
    chk("wb_valid", 64'(wb_valid), 64'(m_wb_valid));
    if (m_wb_valid) begin
      chk("wb_regno", 64'(wb_regno), 64'(m_wb_regno));
      chk("wb_data", wb_data, m_wb_data);
    end
  endtask

  // Inputs are set at the falling edge; check, advance the model, move on.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [63:0] val, input bit upd);
    in_valid = 1'b1; in_op = OP_ALU; in_rd_regno = rd; in_alu_result = val; in_update_rd = upd;
  endtask

  task automatic set_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
    in_valid = 1'b1; in_op = OP_STORE; in_addr = a; in_store_data = d; in_size = sz;
    in_update_rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int k;
    // power-up reset, outputs not yet defined before the first edge
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    tick();
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_sb_count", 64'(sb_count), 64'd0);
    chk("reset_halt", 64'(halt), 64'd0);
    reset = 1'b0;

    // ALU writeback and rd==0 suppression
    set_alu(5'd5, 64'h1234, 1'b1);
    tick();
    chk("alu_wb_valid", 64'(wb_valid), 64'd1);
    chk("alu_wb_regno", 64'(wb_regno), 64'd5);
    chk("alu_wb_data", wb_data, 64'h1234);
    set_alu(5'd0, 64'h9999, 1'b1);
    tick();
    chk("rd0_wb_valid", 64'(wb_valid), 64'd0);
    in_valid = 1'b1; in_op = OP_LOAD; in_rd_regno = 5'd3; in_mdata = 64'hDEAD; in_alu_result = 64'h1;
    in_update_rd = 1'b1;
    tick();
    chk("load_wb_data", wb_data, 64'hDEAD);

    // fill the buffer with byte stores while memory is not ready
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(64'h100 + 64'(i), 64'h1FF + 64'(i), 2'd0);
      tick();
    end
    chk("sb_count_full", 64'(sb_count), 64'd4);
    set_store(64'h104, 64'h2AB, 2'd0);
    #1;
    chk("full_stall_ready", 64'(in_ready), 64'd0);
    chk("head_addr", mem_addr, 64'h100);
    chk("head_byte_data", mem_data, 64'hFF);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("full_pop_ready", 64'(in_ready), 64'd1);
    tick();
    chk("push_pop_count", 64'(sb_count), 64'd4);
    chk("fifo_order_head", mem_addr, 64'h101);
    in_valid = 1'b0;
    for (k = 0; k < 10 && sb_count != 3'd0; k++) tick();
    chk("drained", 64'(sb_count), 64'd0);

    // ECALL behind two queued stores
    mem_ready = 1'b0;
    set_store(64'h200, 64'h1122334455667788, 2'd2); tick();
    set_store(64'h208, 64'hAABB, 2'd1); tick();
    in_valid = 1'b1; in_op = OP_ECALL;
    #1;
    chk("ecall_flush", 64'(syscall_flush), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("flush_one_cycle", 64'(syscall_flush), 64'd0);
    chk("no_req_while_queued", 64'(ecall_req), 64'd0);
    tick();
    mem_ready = 1'b1;
    for (k = 0; k < 20 && !ecall_req; k++) tick();
    chk("ecall_req_seen", 64'(ecall_req), 64'd1);
    chk("ecall_req_after_drain", 64'(sb_count), 64'd0);
    ecall_ack = 1'b1; ecall_ret = 64'd42;
    tick();
    ecall_ack = 1'b0;
    chk("a0_wb_valid", 64'(wb_valid), 64'd1);
    chk("a0_wb_regno", 64'(wb_regno), 64'd10);
    chk("a0_wb_data", wb_data, 64'd42);
    tick();
    set_alu(5'd1, 64'h7, 1'b1);
    #1;
    chk("ready_after_syscall", 64'(in_ready), 64'd1);
    tick();

    // reset during DRAIN discards stores; reset during CALL clears everything
    mem_ready = 1'b0;
    set_store(64'h300, 64'h5, 2'd3); tick();
    in_op = OP_ECALL; tick();
    in_valid = 1'b0; tick();
    reset = 1'b1; tick();
    chk("drain_reset_count", 64'(sb_count), 64'd0);
    reset = 1'b0;
    in_valid = 1'b1; in_op = OP_ECALL; tick();
    in_valid = 1'b0;
    for (k = 0; k < 20 && !ecall_req; k++) tick();
    chk("call_reached", 64'(ecall_req), 64'd1);
    reset = 1'b1; tick();
    chk("call_reset_req", 64'(ecall_req), 64'd0);
    chk("call_reset_wb", 64'(wb_valid), 64'd0);
    chk("call_reset_ready", 64'(in_ready), 64'd0);
    chk("call_reset_mem_valid", 64'(mem_valid), 64'd0);
    reset = 1'b0;
    set_alu(5'd7, 64'h55, 1'b1);
    tick();
    chk("post_reset_alu", wb_data, 64'h55);
    chk("post_reset_regno", 64'(wb_regno), 64'd7);

    // HALT waits for the buffer to empty
    mem_ready = 1'b0;
    set_store(64'h400, 64'h1, 2'd0); tick();
    set_store(64'h401, 64'h2, 2'd0); tick();
    in_op = OP_HALT;
    #1;
    chk("halt_stall", 64'(in_ready), 64'd0);
    tick(); tick();
    mem_ready = 1'b1;
    for (k = 0; k < 20 && !halt; k++) tick();
    chk("halt_set", 64'(halt), 64'd1);
    chk("halt_buffer_empty", 64'(sb_count), 64'd0);
    set_alu(5'd2, 64'h3, 1'b1);
    #1;
    chk("halt_no_accept", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b1; tick();
    reset = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 30) in_op = OP_ALU;
      else if (r < 45) in_op = OP_LOAD;
      else if (r < 80) in_op = OP_STORE;
      else if (r < 85) in_op = OP_ECALL;
      else if (r < 87) in_op = OP_HALT;
      else if (r < 94) in_op = OP_NOP;
      else in_op = 3'($urandom_range(6, 7));
      in_size = 2'($urandom_range(0, 3));
      in_alu_result = {$urandom, $urandom};
      in_mdata = {$urandom, $urandom};
      in_store_data = {$urandom, $urandom};
      in_addr = {$urandom, $urandom};
      in_rd_regno = 5'($urandom_range(0, 31));
      in_update_rd = ($urandom_range(0, 4) != 0);
      mem_ready = ((c % 400) < 100) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
      ecall_ack = ($urandom_range(0, 3) == 0);
      ecall_ret = {$urandom, $urandom};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
